// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared types and defaults for the counter sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Default width of the observed free-running counter.
  localparam int COUNTER_WIDTH = 4;

  // Width of the consecutive-good-step counter; holds LOCK_CNT up to 15.
  localparam int GOOD_W = 4;

  // Checker lock state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating event counter with synchronous clear. It sticks at
//            all-ones once there.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step up unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module   : counter_checker
// Purpose  : Monitors a free-running counter value, locks onto a correct
//            +1 (mod 2^WIDTH) sequence, and reports sequence errors and
//            wrap-arounds with pulses and saturating statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = COUNTER_WIDTH,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] q_in,
  input  logic             en,
  input  logic             clr,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] wrap_cnt
);

  // Lock threshold in the width of the good-step counter.
  localparam logic [GOOD_W-1:0] c_lock_cnt = GOOD_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0]  c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GOOD_W-1:0] c_good_one = {{(GOOD_W-1){1'b0}}, 1'b1};

  state_e            state_q,      state_d;
  logic [WIDTH-1:0]  prev_q,       prev_d;
  logic [GOOD_W-1:0] good_q,       good_d;
  logic [WIDTH-1:0]  expected_q,   expected_d;
  logic              locked_q,     locked_d;
  logic              err_pulse_q;
  logic              wrap_pulse_q;

  logic [WIDTH-1:0]  w_prev_inc;
  logic [GOOD_W-1:0] w_good_inc;
  logic              w_match;
  logic              w_prev_max;
  logic              w_err_fire;
  logic              w_wrap_fire;

  // Width-truncated successor of the previous sample: all-ones expects 0.
  assign w_prev_inc = prev_q + c_one;
  assign w_good_inc = good_q + c_good_one;
  assign w_match    = (q_in == w_prev_inc);
  assign w_prev_max = &prev_q;

  // Next-state and event decode; clear outranks a qualified sample.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    expected_d  = expected_q;
    w_err_fire  = 1'b0;
    w_wrap_fire = 1'b0;

    if (clr) begin
      state_d    = ST_IDLE;
      prev_d     = '0;
      good_d     = '0;
      expected_d = '0;
    end else if (en) begin
      // Every qualified sample becomes the new reference value.
      prev_d     = q_in;
      expected_d = q_in + c_one;

      unique case (state_q)
        ST_IDLE: begin
          // First sample only seeds the reference; nothing is judged yet.
          good_d  = '0;
          state_d = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          if (w_match) begin
            good_d      = w_good_inc;
            w_wrap_fire = w_prev_max;
            if (w_good_inc == c_lock_cnt) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end

        ST_LOCKED: begin
          if (w_match) begin
            w_wrap_fire = w_prev_max;
          end else begin
            // Losing the sequence is only an error once we were locked.
            w_err_fire = 1'b1;
            good_d     = '0;
            state_d    = ST_ACQUIRE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  // Lock indication follows the state being entered.
  assign locked_d = (state_d == ST_LOCKED);

  // State and output registers, discarded immediately on reset.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_pulse_q  <= w_err_fire;
      wrap_pulse_q <= w_wrap_fire;
    end
  end

  // Error statistics: counts every error, holds at its maximum.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rs  (rs),
    .clr (clr),
    .inc (w_err_fire),
    .cnt (err_cnt)
  );

  // Wrap statistics: counts correct all-ones to zero steps.
  sat_counter #(
    .W (ERR_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rs  (rs),
    .clr (clr),
    .inc (w_wrap_fire),
    .cnt (wrap_cnt)
  );

  assign locked     = locked_q;
  assign expected   = expected_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule : counter_checker
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_checker
// Purpose  : Self-checking bench for counter_checker. A default instance and
//            a narrow-statistics instance (ERR_W=2) see the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_checker;

  logic       clk;
  logic       rs;
  logic [3:0] q_in;
  logic       en;
  logic       clr;

  logic       locked,  locked_s;
  logic [3:0] expv,    expv_s;
  logic       errp,    errp_s;
  logic [7:0] errc;
  logic [1:0] errc_s;
  logic       wrapp,   wrapp_s;
  logic [7:0] wrapc;
  logic [1:0] wrapc_s;

  counter_checker #(.WIDTH(4), .ERR_W(8), .LOCK_CNT(2)) dut (
    .clk(clk), .rs(rs), .q_in(q_in), .en(en), .clr(clr),
    .locked(locked), .expected(expv), .err_pulse(errp), .err_cnt(errc),
    .wrap_pulse(wrapp), .wrap_cnt(wrapc)
  );

  counter_checker #(.WIDTH(4), .ERR_W(2), .LOCK_CNT(2)) dut_s (
    .clk(clk), .rs(rs), .q_in(q_in), .en(en), .clr(clr),
    .locked(locked_s), .expected(expv_s), .err_pulse(errp_s), .err_cnt(errc_s),
    .wrap_pulse(wrapp_s), .wrap_cnt(wrapc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       locked;
    logic [3:0] expv;
    logic       errp;
    int         errc;
    logic       wrapp;
    int         wrapc;
  } exp_t;

  exp_t q_sb[$];

  int n_err;
  int n_chk;
  int n_errpulse_seen;

  // Reference model state (IDLE=0, ACQUIRE=1, LOCKED=2).
  int         m_st;
  logic [3:0] m_prev;
  int         m_good;
  exp_t       m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_prev = 4'd0; m_good = 0;
    m.locked = 1'b0; m.expv = 4'd0; m.errp = 1'b0; m.errc = 0;
    m.wrapp = 1'b0; m.wrapc = 0;
  endtask

  task automatic model_step(input logic s_en, input logic s_clr, input logic [3:0] s_q);
    logic [3:0] succ;
    m.errp  = 1'b0;
    m.wrapp = 1'b0;
    succ    = m_prev + 4'd1;
    if (s_clr) begin
      model_reset();
    end else if (s_en) begin
      if (m_st == 0) begin
        m_good = 0;
        m_st   = 1;
      end else if (s_q == succ) begin
        if (m_prev == 4'hF) begin
          m.wrapp = 1'b1;
          m.wrapc++;
        end
        if (m_st == 1) begin
          m_good++;
          if (m_good == 2) m_st = 2;
        end
      end else begin
        m_good = 0;
        if (m_st == 2) begin
          m.errp = 1'b1;
          m.errc++;
          m_st = 1;
        end
      end
      m_prev = s_q;
      m.expv = s_q + 4'd1;
    end
    m.locked = (m_st == 2);
  endtask

  // Compare both instances against one popped scoreboard entry.
  task automatic compare_entry(input string tag);
    exp_t e;
    if (q_sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = q_sb.pop_front();
    chk({tag, ".locked"},  32'(locked), 32'(e.locked));
    chk({tag, ".expected"}, 32'(expv),  32'(e.expv));
    chk({tag, ".err_pulse"}, 32'(errp), 32'(e.errp));
    chk({tag, ".err_cnt"},  32'(errc),  32'((e.errc > 255) ? 255 : e.errc));
    chk({tag, ".wrap_pulse"}, 32'(wrapp), 32'(e.wrapp));
    chk({tag, ".wrap_cnt"}, 32'(wrapc), 32'((e.wrapc > 255) ? 255 : e.wrapc));
    chk({tag, ".s.locked"}, 32'(locked_s), 32'(e.locked));
    chk({tag, ".s.err_pulse"}, 32'(errp_s), 32'(e.errp));
    chk({tag, ".s.err_cnt"}, 32'(errc_s), 32'((e.errc > 3) ? 3 : e.errc));
    chk({tag, ".s.wrap_cnt"}, 32'(wrapc_s), 32'((e.wrapc > 3) ? 3 : e.wrapc));
    if (errp_s) n_errpulse_seen++;
  endtask

  // Drive one cycle at the falling edge, predict, then check after the edge.
  task automatic step(input string tag, input logic s_en, input logic s_clr, input logic [3:0] s_q);
    @(negedge clk);
    en   = s_en;
    clr  = s_clr;
    q_in = s_q;
    model_step(s_en, s_clr, s_q);
    q_sb.push_back(m);
    @(posedge clk);
    #1;
    compare_entry(tag);
  endtask

  task automatic feed(input string tag, input int from, input int to);
    for (int v = from; v <= to; v++) step(tag, 1'b1, 1'b0, 4'(v));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0; n_chk = 0; n_errpulse_seen = 0;
    rs = 1'b0; en = 1'b0; clr = 1'b0; q_in = 4'd0;
    model_reset();

    // Reset state.
    #3;
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.expected", 32'(expv), 32'd0);
    chk("rst.err_cnt", 32'(errc), 32'd0);
    chk("rst.wrap_cnt", 32'(wrapc), 32'd0);
    chk("rst.pulses", 32'({errp, wrapp}), 32'd0);
    @(negedge clk);
    rs = 1'b1;

    // 1. Lock on 0,1,2,3.
    step("lock0", 1'b1, 1'b0, 4'd0);
    step("lock1", 1'b1, 1'b0, 4'd1);
    step("lock2", 1'b1, 1'b0, 4'd2);
    chk("lock.locked_after2", 32'(locked), 32'd1);
    chk("lock.expected3", 32'(expv), 32'd3);
    step("lock3", 1'b1, 1'b0, 4'd3);
    chk("lock.expected4", 32'(expv), 32'd4);

    // 2. Wrap through 15 -> 0.
    feed("run", 4, 13);
    step("wrap14", 1'b1, 1'b0, 4'd14);
    step("wrap15", 1'b1, 1'b0, 4'd15);
    step("wrap0", 1'b1, 1'b0, 4'd0);
    chk("wrap.pulse", 32'(wrapp), 32'd1);
    chk("wrap.cnt", 32'(wrapc), 32'd1);
    step("wrap1", 1'b1, 1'b0, 4'd1);
    chk("wrap.pulse_gone", 32'(wrapp), 32'd0);

    // 3. Error at 5 -> 7, then relock on 8,9.
    feed("pre_err", 2, 5);
    step("err7", 1'b1, 1'b0, 4'd7);
    chk("err.pulse", 32'(errp), 32'd1);
    chk("err.unlocked", 32'(locked), 32'd0);
    chk("err.expected8", 32'(expv), 32'd8);
    step("relock8", 1'b1, 1'b0, 4'd8);
    step("relock9", 1'b1, 1'b0, 4'd9);
    chk("relock.locked", 32'(locked), 32'd1);

    // 4. en gaps then clear priority.
    feed("to4", 10, 15);
    feed("to4b", 0, 4);
    step("gapA", 1'b0, 1'b0, 4'h9);
    step("gapB", 1'b0, 1'b0, 4'hA);
    step("gapC", 1'b0, 1'b0, 4'hB);
    chk("gap.locked_held", 32'(locked), 32'd1);
    chk("gap.expected_held", 32'(expv), 32'd5);
    step("after_gap5", 1'b1, 1'b0, 4'd5);
    chk("after_gap.locked", 32'(locked), 32'd1);
    step("clr", 1'b1, 1'b1, 4'd0);
    chk("clr.all_zero", 32'({locked, expv, errp, errc, wrapp, wrapc}), 32'd0);

    // 5. Saturation: five lock/error rounds; narrow counter stops at 3.
    n_errpulse_seen = 0;
    for (int r = 0; r < 5; r++) begin
      feed("sat_lock", 3 * r, 3 * r + 2);
      step("sat_err", 1'b1, 1'b0, 4'(3 * r + 2 + 5));
    end
    chk("sat.narrow_err_cnt", 32'(errc_s), 32'd3);
    chk("sat.wide_err_cnt", 32'(errc), 32'd5);
    chk("sat.pulses_seen", 32'(n_errpulse_seen), 32'd5);

    // 6. Async reset while locked with err_cnt=2.
    step("pre_rst_clr", 1'b1, 1'b1, 4'd0);
    feed("ar_a", 0, 2);
    step("ar_e1", 1'b1, 1'b0, 4'd9);
    feed("ar_b", 10, 11);
    step("ar_e2", 1'b1, 1'b0, 4'd1);
    feed("ar_c", 2, 3);
    chk("ar.locked_before", 32'(locked), 32'd1);
    chk("ar.errc_before", 32'(errc), 32'd2);
    #2;
    rs = 1'b0;
    #1;
    model_reset();
    chk("ar.locked", 32'(locked), 32'd0);
    chk("ar.err_cnt", 32'(errc), 32'd0);
    chk("ar.wrap_cnt", 32'(wrapc), 32'd0);
    chk("ar.expected", 32'(expv), 32'd0);
    @(negedge clk);
    rs = 1'b1;
    step("ar_relock0", 1'b1, 1'b0, 4'd0);
    step("ar_relock1", 1'b1, 1'b0, 4'd1);
    chk("ar.not_yet", 32'(locked), 32'd0);
    step("ar_relock2", 1'b1, 1'b0, 4'd2);
    chk("ar.relocked", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_counter_checker
`default_nettype wire
